alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; state cleared while rst=0.
REQ-003 clear  in  1  synchronous flush (branch mispredict); empties all entries.
REQ-004 ALUen  in  1  dispatch valid.
REQ-005 ALUoperandO, ALUoperandT  in  `DataBus  operand values, meaningful when matching tag is `tagFree.
REQ-006 ALUtagO, ALUtagT  in  `TagBus  pending producer tags; `tagFree means value present.
REQ-007 ALUtagW  in  `TagBus  destination rename tag; ALUnameW  in  `NameBus  destination register.
REQ-008 ALUop  in  `OpBus; ALUaddr  in  `InstAddrBus  instruction address.
REQ-009 enCDBalu  in  1; CDBaluTag  in  `TagBus; CDBaluData  in  `DataBus  ALU result broadcast.
REQ-010 enCDBls  in  1; CDBlsTag  in  `TagBus; CDBlsData  in  `DataBus  load result broadcast.
REQ-011 ALUfreeTag  out  `TagRootBus  lowest-index empty entry.
REQ-012 ALUfull  out  1  all entries busy.
REQ-013 exEn, exOperandO, exOperandT, exOp, exTagW, exNameW, exAddr  out  (1, `DataBus x2, `OpBus, `TagBus, `NameBus, `InstAddrBus)  registered issue to ALU.

Function
REQ-014 Eight entries (index = tag root, 0..7); each holds busy, op, two operand value/tag pairs, tagW, nameW, addr.
REQ-015 ALUfreeTag, ALUfull combinational from registered busy vector only; ALUfreeTag=0 when full.
REQ-016 ALUen=1 and not full and clear=0: entry ALUfreeTag written, busy set at edge; ALUen while full ignored.
REQ-017 Wakeup: busy entry operand with tag != `tagFree matching an enabled CDB tag captures that data and sets tag to `tagFree at edge.
REQ-018 Dispatch bypass: incoming ALUtagO/ALUtagT matching an enabled CDB tag in same cycle stored as captured data with `tagFree.
REQ-019 Ready = busy and both tags `tagFree (registered state only).
REQ-020 Issue: lowest-index ready entry driven to ex* outputs at edge, exEn=1, entry busy cleared same edge; none ready -> exEn=0, other ex* hold defaults.
REQ-021 Latency: dispatch with ready operands at edge t -> exEn=1 after edge t+1; CDB wakeup at edge t -> issue eligible at edge t+1.
REQ-022 Dispatch and issue same cycle both take effect; issued entry's slot reusable only from next cycle.
REQ-023 clear=1: all busy cleared, exEn=0 next cycle; clear overrides ALUen and issue.
REQ-024 Both CDBs carrying same tag: ALU bus data wins.

Reset
REQ-025 rst=0: all busy=0; exEn=0, exOperandO/T=`dataFree, exTagW=`tagFree, exNameW=`nameFree, exOp=`NOP, exAddr=0; hence ALUfreeTag=0, ALUfull=0.
REQ-026 rst asserted mid-operation discards all entries and any in-flight issue immediately; no partial entry survives.

Structure
REQ-027 Entry count, `TagBus/`TagRootBus/`DataBus/`NameBus/`OpBus widths, `tagFree, `dataFree, `nameFree, `NOP, `Enable/`Disable, tag prefixes live in defines.v.
REQ-028 One sub-module lowbit_sel (8-bit lowest-set-bit priority encoder, outputs index + found), instantiated twice: free-slot select and ready select.

Verification
REQ-029 Reset then dispatch ADD, tags free, operands 5 and 7, tagW=ALU root 0 -> next edge exEn=1, exOperandO=5, exOperandT=7, ALUfreeTag returns 0.
REQ-030 Dispatch with ALUtagO=LS tag 2; two cycles later enCDBls tag 2 data 0x1234 -> exEn=1 one edge after broadcast with exOperandO=0x1234.
REQ-031 Dispatch with ALUtagT=X while CDBaluTag=X enabled same cycle, data 9 -> issued next edge with exOperandT=9.
REQ-032 Eight dispatches all waiting on tag Y -> ALUfull=1; ninth ALUen ignored; broadcast Y -> entries 0..7 issue on eight consecutive edges in index order.
REQ-033 Four waiting entries, clear=1 with ALUen=1 -> all busy cleared, exEn=0, ALUfreeTag=0, ALUfull=0; no later issue on broadcast.
REQ-034 rst pulsed low mid-stream with exEn=1 -> exEn=0 and defaults immediately, without waiting for clk.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - widths, tag encodings and entry types shared by the ALU reservation station
package alu_rs_pkg;

  localparam int ENTRIES = 8;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 5;
  localparam int ROOT_W  = 3;
  localparam int NAME_W  = 5;
  localparam int OP_W    = 4;
  localparam int ADDR_W  = 32;

  // Tag = {prefix, root}; prefix 00 is reserved so the all-zero tag means "value present".
  localparam logic [1:0]        TAG_PREFIX_ALU = 2'b01;
  localparam logic [1:0]        TAG_PREFIX_LS  = 2'b10;
  localparam logic [TAG_W-1:0]  TAG_FREE       = '0;
  localparam logic [DATA_W-1:0] DATA_FREE      = '0;
  localparam logic [NAME_W-1:0] NAME_FREE      = '0;
  localparam logic [OP_W-1:0]   OP_NOP         = '0;
  localparam logic [ADDR_W-1:0] ADDR_ZERO      = '0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } operand_t;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    operand_t          opnd_o;
    operand_t          opnd_t;
    logic [TAG_W-1:0]  tag_w;
    logic [NAME_W-1:0] name_w;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  // Capture a broadcast result into a pending operand; the ALU bus wins a tag tie.
  function automatic operand_t snoop(
    input operand_t          cur,
    input logic              alu_en,
    input logic [TAG_W-1:0]  alu_tag,
    input logic [DATA_W-1:0] alu_data,
    input logic              ls_en,
    input logic [TAG_W-1:0]  ls_tag,
    input logic [DATA_W-1:0] ls_data
  );
    snoop = cur;
    if (cur.tag != TAG_FREE) begin
      if (alu_en && alu_tag == cur.tag) begin
        snoop.tag  = TAG_FREE;
        snoop.data = alu_data;
      end else if (ls_en && ls_tag == cur.tag) begin
        snoop.tag  = TAG_FREE;
        snoop.data = ls_data;
      end
    end
  endfunction

endpackage

// File: rtl/alu_rs_lowbit_sel.sv
// rtl/alu_rs_lowbit_sel.sv - 8-bit lowest-set-bit priority encoder
module lowbit_sel (
  input  logic [7:0] bits,
  output logic [2:0] index,
  output logic       found
);

  // Scan downward so the lowest set bit is the last (winning) assignment.
  always_comb begin
    index = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (bits[i]) begin
        index = i[2:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - eight-entry ALU reservation station with CDB wakeup and in-order-by-index issue
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ALUen,
  input  logic [DATA_W-1:0] ALUoperandO,
  input  logic [DATA_W-1:0] ALUoperandT,
  input  logic [TAG_W-1:0]  ALUtagO,
  input  logic [TAG_W-1:0]  ALUtagT,
  input  logic [TAG_W-1:0]  ALUtagW,
  input  logic [NAME_W-1:0] ALUnameW,
  input  logic [OP_W-1:0]   ALUop,
  input  logic [ADDR_W-1:0] ALUaddr,
  input  logic              enCDBalu,
  input  logic [TAG_W-1:0]  CDBaluTag,
  input  logic [DATA_W-1:0] CDBaluData,
  input  logic              enCDBls,
  input  logic [TAG_W-1:0]  CDBlsTag,
  input  logic [DATA_W-1:0] CDBlsData,
  output logic [ROOT_W-1:0] ALUfreeTag,
  output logic              ALUfull,
  output logic              exEn,
  output logic [DATA_W-1:0] exOperandO,
  output logic [DATA_W-1:0] exOperandT,
  output logic [OP_W-1:0]   exOp,
  output logic [TAG_W-1:0]  exTagW,
  output logic [NAME_W-1:0] exNameW,
  output logic [ADDR_W-1:0] exAddr
);

  entry_t              entries [ENTRIES];
  logic [ENTRIES-1:0]  busy;
  logic [ENTRIES-1:0]  ready;
  logic [ROOT_W-1:0]   free_idx, rdy_idx;
  logic                free_found, rdy_found;
  logic [ENTRIES-1:0]  disp_mask, issue_mask;
  entry_t              new_entry;

  always_comb begin
    busy  = '0;
    ready = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy[i]  = entries[i].busy;
      ready[i] = entries[i].busy && entries[i].opnd_o.tag == TAG_FREE
                                 && entries[i].opnd_t.tag == TAG_FREE;
    end
  end

  lowbit_sel u_free_sel (.bits(~busy), .index(free_idx), .found(free_found));
  lowbit_sel u_rdy_sel  (.bits(ready), .index(rdy_idx),  .found(rdy_found));

  assign ALUfreeTag = free_idx;
  assign ALUfull    = ~free_found;

  assign disp_mask  = (ALUen && free_found) ? (ENTRIES'(1) << free_idx) : '0;
  assign issue_mask = rdy_found ? (ENTRIES'(1) << rdy_idx) : '0;

  // Operands arriving with a tag that is on a CDB this cycle are captured on the way in.
  always_comb begin
    new_entry        = '0;
    new_entry.busy   = 1'b1;
    new_entry.op     = ALUop;
    new_entry.opnd_o = snoop({ALUtagO, ALUoperandO}, enCDBalu, CDBaluTag, CDBaluData,
                             enCDBls, CDBlsTag, CDBlsData);
    new_entry.opnd_t = snoop({ALUtagT, ALUoperandT}, enCDBalu, CDBaluTag, CDBaluData,
                             enCDBls, CDBlsTag, CDBlsData);
    new_entry.tag_w  = ALUtagW;
    new_entry.name_w = ALUnameW;
    new_entry.addr   = ALUaddr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
      exEn       <= 1'b0;
      exOperandO <= DATA_FREE;
      exOperandT <= DATA_FREE;
      exOp       <= OP_NOP;
      exTagW     <= TAG_FREE;
      exNameW    <= NAME_FREE;
      exAddr     <= ADDR_ZERO;
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) entries[i].busy <= 1'b0;
      exEn       <= 1'b0;
      exOperandO <= DATA_FREE;
      exOperandT <= DATA_FREE;
      exOp       <= OP_NOP;
      exTagW     <= TAG_FREE;
      exNameW    <= NAME_FREE;
      exAddr     <= ADDR_ZERO;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (disp_mask[i]) begin
          entries[i] <= new_entry;
        end else begin
          entries[i].opnd_o <= snoop(entries[i].opnd_o, enCDBalu, CDBaluTag, CDBaluData,
                                     enCDBls, CDBlsTag, CDBlsData);
          entries[i].opnd_t <= snoop(entries[i].opnd_t, enCDBalu, CDBaluTag, CDBaluData,
                                     enCDBls, CDBlsTag, CDBlsData);
          if (issue_mask[i]) entries[i].busy <= 1'b0;
        end
      end
      exEn <= rdy_found;
      if (rdy_found) begin
        exOperandO <= entries[rdy_idx].opnd_o.data;
        exOperandT <= entries[rdy_idx].opnd_t.data;
        exOp       <= entries[rdy_idx].op;
        exTagW     <= entries[rdy_idx].tag_w;
        exNameW    <= entries[rdy_idx].name_w;
        exAddr     <= entries[rdy_idx].addr;
      end else begin
        exOperandO <= DATA_FREE;
        exOperandT <= DATA_FREE;
        exOp       <= OP_NOP;
        exTagW     <= TAG_FREE;
        exNameW    <= NAME_FREE;
        exAddr     <= ADDR_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - directed self-checking bench for alu_rs
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              ALUen;
  logic [DATA_W-1:0] ALUoperandO, ALUoperandT;
  logic [TAG_W-1:0]  ALUtagO, ALUtagT, ALUtagW;
  logic [NAME_W-1:0] ALUnameW;
  logic [OP_W-1:0]   ALUop;
  logic [ADDR_W-1:0] ALUaddr;
  logic              enCDBalu, enCDBls;
  logic [TAG_W-1:0]  CDBaluTag, CDBlsTag;
  logic [DATA_W-1:0] CDBaluData, CDBlsData;
  logic [ROOT_W-1:0] ALUfreeTag;
  logic              ALUfull;
  logic              exEn;
  logic [DATA_W-1:0] exOperandO, exOperandT;
  logic [OP_W-1:0]   exOp;
  logic [TAG_W-1:0]  exTagW;
  logic [NAME_W-1:0] exNameW;
  logic [ADDR_W-1:0] exAddr;

  int errors = 0;
  int checks = 0;

  alu_rs dut (
    .clk(clk), .rst(rst), .clear(clear), .ALUen(ALUen),
    .ALUoperandO(ALUoperandO), .ALUoperandT(ALUoperandT),
    .ALUtagO(ALUtagO), .ALUtagT(ALUtagT), .ALUtagW(ALUtagW),
    .ALUnameW(ALUnameW), .ALUop(ALUop), .ALUaddr(ALUaddr),
    .enCDBalu(enCDBalu), .CDBaluTag(CDBaluTag), .CDBaluData(CDBaluData),
    .enCDBls(enCDBls), .CDBlsTag(CDBlsTag), .CDBlsData(CDBlsData),
    .ALUfreeTag(ALUfreeTag), .ALUfull(ALUfull),
    .exEn(exEn), .exOperandO(exOperandO), .exOperandT(exOperandT),
    .exOp(exOp), .exTagW(exTagW), .exNameW(exNameW), .exAddr(exAddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; ALUen = 1'b0;
    ALUoperandO = '0; ALUoperandT = '0; ALUtagO = '0; ALUtagT = '0;
    ALUtagW = '0; ALUnameW = '0; ALUop = '0; ALUaddr = '0;
    enCDBalu = 1'b0; CDBaluTag = '0; CDBaluData = '0;
    enCDBls = 1'b0; CDBlsTag = '0; CDBlsData = '0;
  endtask

  task automatic dispatch(input logic [TAG_W-1:0] tag_o, input logic [31:0] val_o,
                          input logic [TAG_W-1:0] tag_t, input logic [31:0] val_t,
                          input logic [4:0] name);
    ALUen = 1'b1; ALUop = 4'd1;
    ALUtagO = tag_o; ALUoperandO = val_o;
    ALUtagT = tag_t; ALUoperandT = val_t;
    ALUtagW = {TAG_PREFIX_ALU, 3'd0}; ALUnameW = name; ALUaddr = 32'h100;
  endtask

  localparam logic [TAG_W-1:0] LS2   = 5'b10_010;
  localparam logic [TAG_W-1:0] LS3   = 5'b10_011;
  localparam logic [TAG_W-1:0] LS7   = 5'b10_111;
  localparam logic [TAG_W-1:0] ALU5  = 5'b01_101;
  localparam logic [TAG_W-1:0] ALU6  = 5'b01_110;

  initial begin
    idle_inputs();
    rst = 1'b0;
    #12;
    chk("reset_exEn", 32'(exEn), 0);
    chk("reset_freeTag", 32'(ALUfreeTag), 0);
    chk("reset_full", 32'(ALUfull), 0);
    chk("reset_exOperandO", exOperandO, 0);
    chk("reset_exOp", 32'(exOp), 0);
    rst = 1'b1;
    step();

    // ready ADD 5+7
    dispatch(TAG_FREE, 5, TAG_FREE, 7, 5'd3);
    step();
    idle_inputs();
    chk("add_freeTag_after_dispatch", 32'(ALUfreeTag), 1);
    chk("add_exEn_not_yet", 32'(exEn), 0);
    step();
    chk("add_exEn", 32'(exEn), 1);
    chk("add_exOperandO", exOperandO, 5);
    chk("add_exOperandT", exOperandT, 7);
    chk("add_exOp", 32'(exOp), 1);
    chk("add_exTagW", 32'(exTagW), 32'h08);
    chk("add_exNameW", 32'(exNameW), 3);
    chk("add_exAddr", exAddr, 32'h100);
    chk("add_freeTag_back", 32'(ALUfreeTag), 0);
    step();
    chk("add_exEn_drop", 32'(exEn), 0);

    // wait on LS tag 2, woken two cycles later
    dispatch(LS2, 0, TAG_FREE, 4, 5'd4);
    step();
    idle_inputs();
    chk("ls_wait_exEn0", 32'(exEn), 0);
    step();
    chk("ls_wait_exEn1", 32'(exEn), 0);
    enCDBls = 1'b1; CDBlsTag = LS2; CDBlsData = 32'h1234;
    step();
    idle_inputs();
    chk("ls_woken_not_issued", 32'(exEn), 0);
    step();
    chk("ls_issue_exEn", 32'(exEn), 1);
    chk("ls_issue_opO", exOperandO, 32'h1234);
    chk("ls_issue_opT", exOperandT, 4);
    step();

    // dispatch bypass from ALU CDB
    dispatch(TAG_FREE, 1, ALU5, 0, 5'd5);
    enCDBalu = 1'b1; CDBaluTag = ALU5; CDBaluData = 9;
    step();
    idle_inputs();
    step();
    chk("bypass_exEn", 32'(exEn), 1);
    chk("bypass_opT", exOperandT, 9);
    step();

    // both CDBs carry the same tag: ALU data wins
    dispatch(ALU6, 0, TAG_FREE, 2, 5'd6);
    step();
    idle_inputs();
    enCDBalu = 1'b1; CDBaluTag = ALU6; CDBaluData = 32'hA1;
    enCDBls  = 1'b1; CDBlsTag  = ALU6; CDBlsData  = 32'hB2;
    step();
    idle_inputs();
    step();
    chk("tie_exEn", 32'(exEn), 1);
    chk("tie_alu_wins", exOperandO, 32'hA1);
    step();

    // fill all eight entries, ninth dispatch ignored
    for (int i = 0; i < 8; i++) begin
      dispatch(LS7, 0, TAG_FREE, 32'(i), 5'(i));
      step();
    end
    chk("fill_full", 32'(ALUfull), 1);
    chk("fill_freeTag_zero", 32'(ALUfreeTag), 0);
    dispatch(TAG_FREE, 0, TAG_FREE, 32'h99, 5'd31);
    step();
    idle_inputs();
    chk("ninth_ignored_full", 32'(ALUfull), 1);
    chk("ninth_no_issue", 32'(exEn), 0);
    enCDBls = 1'b1; CDBlsTag = LS7; CDBlsData = 32'hAA;
    step();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("drain%0d_exEn", i), 32'(exEn), 1);
      chk($sformatf("drain%0d_name", i), 32'(exNameW), 32'(i));
      chk($sformatf("drain%0d_opT", i), exOperandT, 32'(i));
      chk($sformatf("drain%0d_opO", i), exOperandO, 32'hAA);
    end
    step();
    chk("drain_done_exEn", 32'(exEn), 0);
    chk("drain_done_full", 32'(ALUfull), 0);

    // flush with a simultaneous dispatch
    for (int i = 0; i < 4; i++) begin
      dispatch(LS3, 0, TAG_FREE, 0, 5'(i));
      step();
    end
    dispatch(TAG_FREE, 1, TAG_FREE, 2, 5'd9);
    clear = 1'b1;
    step();
    idle_inputs();
    chk("clear_exEn", 32'(exEn), 0);
    chk("clear_freeTag", 32'(ALUfreeTag), 0);
    chk("clear_full", 32'(ALUfull), 0);
    enCDBls = 1'b1; CDBlsTag = LS3; CDBlsData = 32'h55;
    step();
    idle_inputs();
    chk("clear_no_issue0", 32'(exEn), 0);
    step();
    chk("clear_no_issue1", 32'(exEn), 0);

    // asynchronous reset while an issue is on the outputs
    dispatch(TAG_FREE, 32'h77, TAG_FREE, 32'h88, 5'd7);
    step();
    idle_inputs();
    step();
    chk("pre_rst_exEn", 32'(exEn), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_exEn", 32'(exEn), 0);
    chk("async_rst_opO", exOperandO, 0);
    chk("async_rst_tagW", 32'(exTagW), 0);
    chk("async_rst_freeTag", 32'(ALUfreeTag), 0);
    rst = 1'b1;
    step();
    chk("post_rst_exEn", 32'(exEn), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
